gfp8_nv_dot_acc: RTL and testbench
==================================

Name: gfp8_nv_dot_acc

Overview:
Parametrised, pipelined GFP8 Native Vector dot-product engine with valid/ready handshake and multi-NV accumulation.
- Per beat: computes one NV dot product (NUM_GROUPS groups x GROUP_SIZE signed 8-bit mantissa pairs, one shared exponent per group per side).
- Folds consecutive NV results into a running GFP accumulator, framed by i_first/i_last.
- Emits one aligned {mantissa, exponent} result per frame.
- Sits between the BCV operand fetch and the result collector; replaces the fixed 4-group, non-accumulating NV dot unit.

Parameters:
- NUM_GROUPS, 4: groups per NV.
- GROUP_SIZE, 32: elements per group; must be a multiple of 8, giving GROUP_SIZE/8 ACX_INT_MULT_ADD per group.
- EXP_BIAS, 15: per-side exponent bias. Group exponent = eL + eR - 2*EXP_BIAS.
- ACC_W, 32: width of the NV sum, the accumulator and the output mantissa (signed).
- EXP_OUT_W, 10: signed output exponent width.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_in_ready  out  1  input beat accepted when i_valid && o_in_ready
- i_first  in  1  beat starts a frame
- i_last  in  1  beat ends a frame
- i_exp_left  in  8*NUM_GROUPS  byte g = group g exponent, unsigned
- i_man_left  in  GROUP_SIZE*8*NUM_GROUPS  group g at bits [g*GROUP_SIZE*8 +: GROUP_SIZE*8]; element e of a group at byte e
- i_exp_right  in  8*NUM_GROUPS  as left
- i_man_right  in  GROUP_SIZE*8*NUM_GROUPS  as left
- o_valid  out  1  result valid
- i_out_ready  in  1  downstream accepts when o_valid && i_out_ready
- o_result_mantissa  out  ACC_W  signed accumulated mantissa
- o_result_exponent  out  EXP_OUT_W  signed accumulated exponent
- o_nv_count  out  16  NVs folded into this result
- o_overflow  out  1  mantissa overflow occurred in this frame

Behaviour:
- Reset: all pipeline registers, valid bits, accumulator, counter and outputs go to 0. o_in_ready is 1 after reset.
- Reset mid-frame discards the frame; no output is produced for it.
- Stall: ce = !(o_valid && !i_out_ready); o_in_ready = ce.
  - When ce=0, all stages freeze and outputs hold stable.
  - Bubbles (valid=0) propagate without touching the accumulator.
- Pipeline, beat accepted at edge k:
  - S0 (k): capture operands, first/last and valid.
  - S1 (k+1): per group, sum of the MLP outputs, registered; group exponent computed at EXP_OUT_W signed width, registered.
  - S2 (k+2): Emax = max group exponent; each group mantissa arithmetic-shifted right by (Emax - Eg); a shift >= ACC_W contributes 0; aligned values summed and registered as (nv_m, nv_e).
  - S3 (k+3): accumulate (below).
- Accumulate at S3:
  - If first: acc = (nv_m, nv_e), count = 1.
  - Else: E = max(acc_e, nv_e); both operands arithmetic-shifted right to E with the same >= ACC_W → 0 rule; acc_m = sum; acc_e = E; count + 1.
  - If last: load the output registers and set o_valid.
  - A beat with first=1 and last=1 produces a single-NV result.
  - first=1 arriving mid-frame silently restarts the accumulator.
  - Beats before any first are treated as first.
- Latency: o_valid rises after edge k+3 for a last beat accepted at edge k. Throughput is 1 NV/cycle.
- o_valid clears on handshake unless a new last result loads in the same cycle (back-to-back frames are legal).
- Overflow (default, wrapping):
  - Signed addition wraps mod 2^ACC_W.
  - o_overflow = sticky OR over the frame of signed-overflow detection on every add.

Optional Feature:
- GFP8_NV_DOT_ACC_SATURATE_EN
  - Defined: NV sum and accumulator adds clamp to +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)); o_overflow still reports the event.
  - Undefined: wrapping as above.

Decomposition:
- Package gfp8_pkg: GFP8_MAN_W=8, GFP8_EXP_W=8, and typedef gfp_result_t {mantissa, exponent}.
- Package also holds function align_shift(value, diff, width), which implements the >= width → 0 rule.
- Sub-module gfp8_group_dot: one group of GROUP_SIZE/8 ACX_INT_MULT_ADD instances plus the adder tree, combinational. Instantiated NUM_GROUPS times.

Test Plan:
- All mantissas 1, all exponents 15, first=last=1 → 128, exponent 0, count 1, o_valid 3 cycles after accept.
- Group0 exponents 16/16, others 15, mantissas 1 → 32 + 3*(32>>>2) = 56, exponent 2.
- Group exponent gap 40 (group0 at 40, others at 0), all mantissas 1 → 32, exponent 40; lower groups contribute 0. Repeat with mantissas -1 → -32; the underflowed groups must give 0, not -1.
- Three-beat frame, each NV = 128 @ exp 0, then immediate next frame → 384 @ exp 0 with count 3; 2nd result follows without a gap.
- i_out_ready low 5 cycles while o_valid → outputs and count stable, o_in_ready = 0; the in-flight beat is not lost when ready returns.
- ACC_W=24, mantissas 127, exponents 15, 5-beat frame:
  - Wrap mode: o_overflow=1 and the wrapped value is checked.
  - SATURATE_EN: 8388607 with o_overflow=1.

Source files
------------

// File: rtl/gfp8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfp8_pkg
// Purpose  : Shared GFP8 field widths, result type and exponent-alignment shift.
// Revision : 1.0 - initial release
// ============================================================================
package gfp8_pkg;

    localparam int GFP8_MAN_W   = 8;
    localparam int GFP8_EXP_W   = 8;
    localparam int GFP8_ALIGN_W = 64;

    typedef struct packed {
        logic signed [GFP8_ALIGN_W-1:0] mantissa;
        logic signed [15:0]             exponent;
    } gfp_result_t;

    // A shift at or beyond the operand width yields 0, never the sign fill.
    function automatic logic signed [GFP8_ALIGN_W-1:0] align_shift(
        input logic signed [GFP8_ALIGN_W-1:0] value,
        input logic        [31:0]             diff,
        input logic        [31:0]             width
    );
        logic signed [GFP8_ALIGN_W-1:0] res;
        if (diff >= width) begin
            res = '0;
        end else begin
            res = value >>> diff;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gfp8_group_dot.sv
`default_nettype none
// ============================================================================
// Module   : gfp8_group_dot
// Purpose  : Combinational dot product of one GFP8 group (8-lane MAC slices).
// Revision : 1.0 - initial release
// ============================================================================
module gfp8_group_dot
    import gfp8_pkg::*;
#(
    parameter int GROUP_SIZE = 32,
    parameter int OUT_W      = 32
) (
    input  logic        [GROUP_SIZE*GFP8_MAN_W-1:0] i_man_left,
    input  logic        [GROUP_SIZE*GFP8_MAN_W-1:0] i_man_right,
    output logic signed [OUT_W-1:0]                 o_sum
);

    localparam int NUM_MLP = GROUP_SIZE / 8;
    localparam int MLP_W   = 2 * GFP8_MAN_W + 3;

    logic signed [MLP_W-1:0] w_mlp [NUM_MLP];

    generate
        for (genvar m = 0; m < NUM_MLP; m++) begin : g_mlp
            logic signed [MLP_W-1:0] w_part;
            always_comb begin
                w_part = '0;
                for (int e = 0; e < 8; e++) begin
                    w_part = w_part + MLP_W'(
                        $signed(i_man_left [(m*8+e)*GFP8_MAN_W +: GFP8_MAN_W]) *
                        $signed(i_man_right[(m*8+e)*GFP8_MAN_W +: GFP8_MAN_W]));
                end
            end
            assign w_mlp[m] = w_part;
        end
    endgenerate

    always_comb begin
        o_sum = '0;
        for (int m = 0; m < NUM_MLP; m++) begin
            o_sum = o_sum + OUT_W'(w_mlp[m]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gfp8_nv_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : gfp8_nv_dot_acc
// Purpose  : Pipelined GFP8 NV dot product with frame accumulation.
//            Define GFP8_NV_DOT_ACC_SATURATE_EN for clamping adds (default wraps).
// Revision : 1.0 - initial release
// ============================================================================
module gfp8_nv_dot_acc
    import gfp8_pkg::*;
#(
    parameter int NUM_GROUPS = 4,
    parameter int GROUP_SIZE = 32,
    parameter int EXP_BIAS   = 15,
    parameter int ACC_W      = 32,
    parameter int EXP_OUT_W  = 10
) (
    input  logic                                         i_clk,
    input  logic                                         i_reset_n,
    input  logic                                         i_valid,
    output logic                                         o_in_ready,
    input  logic                                         i_first,
    input  logic                                         i_last,
    input  logic        [GFP8_EXP_W*NUM_GROUPS-1:0]            i_exp_left,
    input  logic        [GROUP_SIZE*GFP8_MAN_W*NUM_GROUPS-1:0] i_man_left,
    input  logic        [GFP8_EXP_W*NUM_GROUPS-1:0]            i_exp_right,
    input  logic        [GROUP_SIZE*GFP8_MAN_W*NUM_GROUPS-1:0] i_man_right,
    output logic                                         o_valid,
    input  logic                                         i_out_ready,
    output logic signed [ACC_W-1:0]                      o_result_mantissa,
    output logic signed [EXP_OUT_W-1:0]                  o_result_exponent,
    output logic        [15:0]                           o_nv_count,
    output logic                                         o_overflow
);

    localparam int GRP_BITS = GROUP_SIZE * GFP8_MAN_W;
    localparam int SUM_W    = ACC_W + $clog2(NUM_GROUPS) + 1;

    // Returns {overflow, result}; the sum is wide enough to hold every add exactly.
    function automatic logic [ACC_W:0] resolve(input logic signed [SUM_W-1:0] s);
        logic             ovf;
        logic [ACC_W-1:0] val;
        ovf = !((&s[SUM_W-1:ACC_W-1]) || !(|s[SUM_W-1:ACC_W-1]));
        val = s[ACC_W-1:0];
`ifdef GFP8_NV_DOT_ACC_SATURATE_EN
        if (ovf) val = s[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        return {ovf, val};
    endfunction

    logic w_ce;
    assign w_ce       = !(o_valid && !i_out_ready);
    assign o_in_ready = w_ce;

    logic                                         r0_valid, r0_first, r0_last;
    logic [GFP8_EXP_W*NUM_GROUPS-1:0]             r0_exp_l, r0_exp_r;
    logic [GRP_BITS*NUM_GROUPS-1:0]               r0_man_l, r0_man_r;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r0_valid <= 1'b0; r0_first <= 1'b0; r0_last <= 1'b0;
            r0_exp_l <= '0;   r0_exp_r <= '0;
            r0_man_l <= '0;   r0_man_r <= '0;
        end else if (w_ce) begin
            r0_valid <= i_valid; r0_first <= i_first; r0_last <= i_last;
            r0_exp_l <= i_exp_left;  r0_exp_r <= i_exp_right;
            r0_man_l <= i_man_left;  r0_man_r <= i_man_right;
        end
    end

    logic signed [ACC_W-1:0]     w_gsum [NUM_GROUPS];
    logic signed [EXP_OUT_W-1:0] w_gexp [NUM_GROUPS];

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
            gfp8_group_dot #(
                .GROUP_SIZE (GROUP_SIZE),
                .OUT_W      (ACC_W)
            ) u_dot (
                .i_man_left  (r0_man_l[g*GRP_BITS +: GRP_BITS]),
                .i_man_right (r0_man_r[g*GRP_BITS +: GRP_BITS]),
                .o_sum       (w_gsum[g])
            );
            assign w_gexp[g] = EXP_OUT_W'(r0_exp_l[g*GFP8_EXP_W +: GFP8_EXP_W])
                             + EXP_OUT_W'(r0_exp_r[g*GFP8_EXP_W +: GFP8_EXP_W])
                             - EXP_OUT_W'(2 * EXP_BIAS);
        end
    endgenerate

    logic                        r1_valid, r1_first, r1_last;
    logic signed [ACC_W-1:0]     r1_gm [NUM_GROUPS];
    logic signed [EXP_OUT_W-1:0] r1_ge [NUM_GROUPS];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r1_valid <= 1'b0; r1_first <= 1'b0; r1_last <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                r1_gm[g] <= '0;
                r1_ge[g] <= '0;
            end
        end else if (w_ce) begin
            r1_valid <= r0_valid; r1_first <= r0_first; r1_last <= r0_last;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                r1_gm[g] <= w_gsum[g];
                r1_ge[g] <= w_gexp[g];
            end
        end
    end

    logic signed [EXP_OUT_W-1:0] w_emax;
    logic signed [SUM_W-1:0]     w_nv_sum;
    logic        [ACC_W:0]       w_nv_res;

    always_comb begin
        w_emax = r1_ge[0];
        for (int g = 1; g < NUM_GROUPS; g++) begin
            if (r1_ge[g] > w_emax) w_emax = r1_ge[g];
        end
    end

    always_comb begin
        w_nv_sum = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            w_nv_sum = w_nv_sum + SUM_W'(align_shift(GFP8_ALIGN_W'(r1_gm[g]),
                                                     32'(w_emax - r1_ge[g]), ACC_W));
        end
        w_nv_res = resolve(w_nv_sum);
    end

    logic                        r2_valid, r2_first, r2_last, r2_ovf;
    logic signed [ACC_W-1:0]     r2_nv_m;
    logic signed [EXP_OUT_W-1:0] r2_nv_e;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r2_valid <= 1'b0; r2_first <= 1'b0; r2_last <= 1'b0; r2_ovf <= 1'b0;
            r2_nv_m  <= '0;   r2_nv_e  <= '0;
        end else if (w_ce) begin
            r2_valid <= r1_valid; r2_first <= r1_first; r2_last <= r1_last;
            r2_ovf   <= w_nv_res[ACC_W];
            r2_nv_m  <= w_nv_res[ACC_W-1:0];
            r2_nv_e  <= w_emax;
        end
    end

    logic                        r_in_frame, r_acc_ovf;
    logic signed [ACC_W-1:0]     r_acc_m;
    logic signed [EXP_OUT_W-1:0] r_acc_e;
    logic        [15:0]          r_count;

    logic                        w_start;
    logic signed [EXP_OUT_W-1:0] w_e3;
    logic signed [SUM_W-1:0]     w_acc_sum;
    logic        [ACC_W:0]       w_acc_res;
    logic signed [ACC_W-1:0]     w_acc_m_nx;
    logic signed [EXP_OUT_W-1:0] w_acc_e_nx;
    logic        [15:0]          w_cnt_nx;
    logic                        w_ovf_nx;

    // A beat with no open frame starts one even without i_first.
    always_comb begin
        w_start   = r2_first || !r_in_frame;
        w_e3      = (r_acc_e > r2_nv_e) ? r_acc_e : r2_nv_e;
        w_acc_sum = SUM_W'(align_shift(GFP8_ALIGN_W'(r_acc_m), 32'(w_e3 - r_acc_e), ACC_W))
                  + SUM_W'(align_shift(GFP8_ALIGN_W'(r2_nv_m), 32'(w_e3 - r2_nv_e), ACC_W));
        w_acc_res = resolve(w_acc_sum);
        if (w_start) begin
            w_acc_m_nx = r2_nv_m;
            w_acc_e_nx = r2_nv_e;
            w_cnt_nx   = 16'd1;
            w_ovf_nx   = r2_ovf;
        end else begin
            w_acc_m_nx = w_acc_res[ACC_W-1:0];
            w_acc_e_nx = w_e3;
            w_cnt_nx   = r_count + 16'd1;
            w_ovf_nx   = r_acc_ovf || r2_ovf || w_acc_res[ACC_W];
        end
    end

    logic                        r_out_valid, r_out_ovf;
    logic signed [ACC_W-1:0]     r_out_m;
    logic signed [EXP_OUT_W-1:0] r_out_e;
    logic        [15:0]          r_out_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_frame  <= 1'b0; r_acc_ovf <= 1'b0;
            r_acc_m     <= '0;   r_acc_e   <= '0;   r_count   <= '0;
            r_out_valid <= 1'b0; r_out_ovf <= 1'b0;
            r_out_m     <= '0;   r_out_e   <= '0;   r_out_cnt <= '0;
        end else if (w_ce) begin
            if (r2_valid) begin
                r_acc_m    <= w_acc_m_nx;
                r_acc_e    <= w_acc_e_nx;
                r_count    <= w_cnt_nx;
                r_acc_ovf  <= w_ovf_nx;
                r_in_frame <= !r2_last;
            end
            if (r2_valid && r2_last) begin
                r_out_valid <= 1'b1;
                r_out_m     <= w_acc_m_nx;
                r_out_e     <= w_acc_e_nx;
                r_out_cnt   <= w_cnt_nx;
                r_out_ovf   <= w_ovf_nx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_valid           = r_out_valid;
    assign o_result_mantissa = r_out_m;
    assign o_result_exponent = r_out_e;
    assign o_nv_count        = r_out_cnt;
    assign o_overflow        = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gfp8_nv_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfp8_nv_dot_acc
// Purpose  : Directed self-checking bench for gfp8_nv_dot_acc (ACC_W 32 and 24).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfp8_nv_dot_acc;

    localparam int NG = 4;
    localparam int GS = 32;
    localparam int MW = GS * 8 * NG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, i_valid, i_first, i_last, i_out_ready;
    logic [8*NG-1:0]   exp_l, exp_r;
    logic [MW-1:0]     man_l, man_r;

    logic              o_in_ready, o_valid, o_ovf;
    logic signed [31:0] o_m;
    logic signed [9:0] o_e;
    logic [15:0]       o_cnt;

    logic              rdy24, v24, ovf24;
    logic signed [23:0] m24;
    logic signed [9:0] e24;
    logic [15:0]       cnt24;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    gfp8_nv_dot_acc dut (
        .i_clk (clk), .i_reset_n (rst_n), .i_valid (i_valid), .o_in_ready (o_in_ready),
        .i_first (i_first), .i_last (i_last),
        .i_exp_left (exp_l), .i_man_left (man_l), .i_exp_right (exp_r), .i_man_right (man_r),
        .o_valid (o_valid), .i_out_ready (i_out_ready),
        .o_result_mantissa (o_m), .o_result_exponent (o_e),
        .o_nv_count (o_cnt), .o_overflow (o_ovf)
    );

    gfp8_nv_dot_acc #(.ACC_W(24)) dut24 (
        .i_clk (clk), .i_reset_n (rst_n), .i_valid (i_valid), .o_in_ready (rdy24),
        .i_first (i_first), .i_last (i_last),
        .i_exp_left (exp_l), .i_man_left (man_l), .i_exp_right (exp_r), .i_man_right (man_r),
        .o_valid (v24), .i_out_ready (i_out_ready),
        .o_result_mantissa (m24), .o_result_exponent (e24),
        .o_nv_count (cnt24), .o_overflow (ovf24)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_ops(input logic [7:0] ml, input logic [7:0] mr,
                           input logic [7:0] el, input logic [7:0] er);
        man_l = {(MW/8){ml}};
        man_r = {(MW/8){mr}};
        exp_l = {NG{el}};
        exp_r = {NG{er}};
    endtask

    task automatic set_g0_exp(input logic [7:0] el, input logic [7:0] er);
        exp_l[7:0] = el;
        exp_r[7:0] = er;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic f, input logic l);
        int guard;
        guard   = 0;
        i_valid = 1'b1; i_first = f; i_last = l;
        while (!o_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_err++;
            $error("FAIL beat_accept observed=timeout expected=ready");
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 40) begin
            n_err++;
            $error("FAIL wait_out observed=timeout expected=o_valid");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_out_ready = 1'b1;
        set_ops(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_mant", o_m, 0);
        chk("rst_count", o_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform NV: 4 groups x 32 x (1*1) at exponent 0
        set_ops(8'd1, 8'd1, 8'd15, 8'd15);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t1_latency", lat, 3);
        chk("t1_mant", o_m, 128);
        chk("t1_exp", o_e, 0);
        chk("t1_count", o_cnt, 1);
        chk("t1_ovf", o_ovf, 0);
        @(negedge clk);
        chk("t1_valid_drop", o_valid, 0);

        // Group 0 two exponents higher: 32 + 3*(32>>>2)
        set_g0_exp(8'd16, 8'd16);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t2_mant", o_m, 56);
        chk("t2_exp", o_e, 2);
        @(negedge clk);

        // Gap of 40 exceeds ACC_W: lower groups vanish
        set_ops(8'd1, 8'd1, 8'd15, 8'd15);
        set_g0_exp(8'd35, 8'd35);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t3_mant_pos", o_m, 32);
        chk("t3_exp_pos", o_e, 40);
        @(negedge clk);
        set_ops(8'hFF, 8'd1, 8'd15, 8'd15);
        set_g0_exp(8'd35, 8'd35);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t3_mant_neg", o_m, -32);
        chk("t3_exp_neg", o_e, 40);
        @(negedge clk);

        // Three-beat frame immediately followed by a single-beat frame
        set_ops(8'd1, 8'd1, 8'd15, 8'd15);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t4_mant", o_m, 384);
        chk("t4_exp", o_e, 0);
        chk("t4_count", o_cnt, 3);
        @(negedge clk);
        chk("t4b_valid", o_valid, 1);
        chk("t4b_mant", o_m, 128);
        chk("t4b_count", o_cnt, 1);
        @(negedge clk);
        chk("t4_valid_drop", o_valid, 0);

        // Downstream stall with a second beat in flight
        i_out_ready = 1'b0;
        beat(1'b1, 1'b1);
        set_ops(8'd2, 8'd1, 8'd15, 8'd15);
        beat(1'b1, 1'b1);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", o_valid, 1);
            chk("t5_hold_mant", o_m, 128);
            chk("t5_hold_count", o_cnt, 1);
            chk("t5_in_ready", o_in_ready, 0);
            @(negedge clk);
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        chk("t5_next_valid", o_valid, 1);
        chk("t5_next_mant", o_m, 256);
        chk("t5_next_count", o_cnt, 1);
        @(negedge clk);
        chk("t5_valid_drop", o_valid, 0);

        // i_first mid-frame restarts the accumulator
        set_ops(8'd1, 8'd1, 8'd15, 8'd15);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b1);
        wait_out(lat);
        chk("t6_mant", o_m, 128);
        chk("t6_count", o_cnt, 1);
        @(negedge clk);

        // Reset mid-frame discards it; next beat without first opens a frame
        beat(1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b0, 1'b1);
        wait_out(lat);
        chk("t7_latency", lat, 3);
        chk("t7_mant", o_m, 128);
        chk("t7_count", o_cnt, 1);
        @(negedge clk);

        // Five NVs of 4*32*127*127 = 2064512 overflow a 24-bit accumulator
        set_ops(8'd127, 8'd127, 8'd15, 8'd15);
        beat(1'b1, 1'b0);
        repeat (3) beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        wait_out(lat);
        chk("t8_mant32", o_m, 10322560);
        chk("t8_ovf32", o_ovf, 0);
        chk("t8_count32", o_cnt, 5);
        chk("t8_valid24", v24, 1);
        chk("t8_count24", cnt24, 5);
        chk("t8_ovf24", ovf24, 1);
        chk("t8_exp24", e24, 0);
`ifdef GFP8_NV_DOT_ACC_SATURATE_EN
        chk("t8_mant24_sat", m24, 8388607);
`else
        chk("t8_mant24_wrap", m24, -6454656);
`endif
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
